// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
//   Exhaustive stimulus/checker for a small combinational block. Steps vec_out
//   through every input combination in ascending order, holds each vector for
//   SETTLE_CYCLES clocks, samples dut_in for one cycle and compares it with the
//   golden truth table. Reports pass, mismatch count and the first failing vector.
//
// Ports
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   start            level request, accepted only in IDLE
//   expected_tt      golden truth table, bit i = expected output for vector i
//   dut_in           output of the block under test (driven from vec_out)
//   vec_out          stimulus vector, MSB = first block input
//   busy             high from start acceptance through the final sample
//   done             one-cycle pulse at the end of a run
//   pass             last completed run had zero mismatches
//   mismatch_count   mismatches in the current/last run
//   first_fail_vec   lowest mismatching vector
//   first_fail_valid first_fail_vec is meaningful
//   observed_tt      captured responses (zero unless TRUTH_TABLE_CAPTURE_EN)
//
// Build option
//   TRUTH_TABLE_CAPTURE_EN : when defined, every sampled response is stored in
//                            observed_tt; otherwise observed_tt is tied to 0.
//
// State | meaning
//   IDLE   | waiting for start; results from the last run are held
//   SETTLE | vec_out applied, waiting for the block output to settle
//   SAMPLE | one cycle: compare dut_in, then advance or finish
//   DONE   | one cycle: done pulse, back to IDLE
module truth_table_sequencer #(
  parameter int N_INPUTS      = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [(1<<N_INPUTS)-1:0]   expected_tt,
  input  logic                       dut_in,
  output logic [N_INPUTS-1:0]        vec_out,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [N_INPUTS:0]          mismatch_count,
  output logic [N_INPUTS-1:0]        first_fail_vec,
  output logic                       first_fail_valid,
  output logic [(1<<N_INPUTS)-1:0]   observed_tt
);

  localparam int NVEC = 1 << N_INPUTS;
  localparam int CW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [N_INPUTS-1:0] VEC_LAST    = '1;
  localparam logic [CW-1:0]       SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [N_INPUTS-1:0]   vec_q, vec_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  pass_q, pass_d;
  logic [N_INPUTS:0]     mcnt_q, mcnt_d;
  logic [N_INPUTS-1:0]   ffv_q, ffv_d;
  logic                  ffvalid_q, ffvalid_d;
  logic                  mismatch;
  logic                  accept;

  assign mismatch = (dut_in != expected_tt[vec_q]);
  assign accept   = (state_q == S_IDLE) && start;

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    pass_d    = pass_q;
    mcnt_d    = mcnt_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d     = '0;
          cnt_d     = '0;
          mcnt_d    = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          mcnt_d = mcnt_q + 1'b1;
          if (!ffvalid_q) begin
            ffv_d     = vec_q;
            ffvalid_d = 1'b1;
          end
        end
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          // Verdict is registered from the final count (including this sample)
          // so it is already valid during the done pulse.
          pass_d  = (mcnt_d == '0);
        end else begin
          vec_d   = vec_q + 1'b1;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      vec_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      pass_q    <= 1'b0;
      mcnt_q    <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      pass_q    <= pass_d;
      mcnt_q    <= mcnt_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

`ifdef TRUTH_TABLE_CAPTURE_EN
  logic [NVEC-1:0] obs_q, obs_d;

  always_comb begin
    obs_d = obs_q;
    if (accept) begin
      obs_d = '0;
    end else if (state_q == S_SAMPLE) begin
      obs_d[vec_q] = dut_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      obs_q <= '0;
    end else begin
      obs_q <= obs_d;
    end
  end

  assign observed_tt = obs_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign observed_tt   = '0;
`endif

  assign vec_out          = vec_q;
  assign busy             = busy_q;
  assign done             = (state_q == S_DONE);
  assign pass             = pass_q;
  assign mismatch_count   = mcnt_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule
